// File: rtl/bitwise_op_scheduler.sv
// Two-requester round-robin scheduler for AND/OR/XOR/repeated right-shift ops.
// Accept-to-result: 2 cycles, or 1+max(1,shamt) for RS1; one op in flight, result held until rsp_ready.
module bitwise_op_scheduler #(
    parameter int N = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [N-1:0]  req0_a,
    input  logic [N-1:0]  req0_b,
    input  logic [1:0]    req0_op,
    input  logic [SW-1:0] req0_shamt,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [N-1:0]  req1_a,
    input  logic [N-1:0]  req1_b,
    input  logic [1:0]    req1_op,
    input  logic [SW-1:0] req1_shamt,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [N-1:0]  rsp_result,
    output logic          rsp_id,
    output logic          busy
);
    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_RS1 = 2'd3;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state;
    logic          last_grant;
    logic          id_r;
    logic [N-1:0]  acc;
    logic [N-1:0]  b_r;
    logic [1:0]    op_r;
    logic [SW-1:0] cnt;
    logic          grant0;
    logic          grant1;

    // last_grant==1 means requester 0 wins the next tie
    assign grant0 = req0_valid & (~req1_valid | last_grant);
    assign grant1 = req1_valid & ~grant0;

    // Gated by rst so nothing is accepted while the block is held in reset
    assign req0_ready = ~rst & (state == IDLE) & grant0;
    assign req1_ready = ~rst & (state == IDLE) & grant1;

    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);
    assign rsp_result = acc;
    assign rsp_id     = id_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            acc        <= '0;
            cnt        <= '0;
            id_r       <= 1'b0;
            b_r        <= '0;
            op_r       <= OP_AND;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready | req1_ready) begin
                        id_r       <= req1_ready;
                        last_grant <= req1_ready;
                        acc        <= req1_ready ? req1_a     : req0_a;
                        b_r        <= req1_ready ? req1_b     : req0_b;
                        op_r       <= req1_ready ? req1_op    : req0_op;
                        cnt        <= req1_ready ? req1_shamt : req0_shamt;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    case (op_r)
                        OP_AND: acc <= acc & b_r;
                        OP_OR:  acc <= acc | b_r;
                        OP_XOR: acc <= acc ^ b_r;
                        default: begin
                            if (cnt != '0) begin
                                acc <= acc >> 1;
                                cnt <= cnt - SW'(1);
                            end
                        end
                    endcase
                    // shamt=0 still spends one EXEC cycle, leaving acc = a
                    if ((op_r != OP_RS1) || (cnt <= SW'(1))) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
